// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch unit: a single-outstanding memory request FSM feeding a prefetch FIFO.
// Optional macro FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module instruction_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);

  localparam int                AW      = $clog2(DEPTH);
  localparam int                CW      = AW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]       NOP     = 32'h0000_0013;
  localparam logic [1:0]        S_IDLE  = 2'd0;
  localparam logic [1:0]        S_REQ   = 2'd1;
  localparam logic [1:0]        S_WAIT  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   req_addr;
  logic          discard, discard_nxt;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   redir_pc;
  logic          misalign_hit, halted, redirect_eff;
  logic          push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;

  assign redir_pc     = redirect_pc;
  assign misalign_hit = redirect && !misaligned_q && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            misaligned_q <= 1'b0;
    else if (misalign_hit) misaligned_q <= 1'b1;
  end

  assign halted           = misaligned_q;
  assign fetch_misaligned = misaligned_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_pc             = {redirect_pc[31:2], 2'b00};
  assign misalign_hit         = 1'b0;
  assign halted               = 1'b0;
  assign fetch_misaligned     = 1'b0;
`endif

  // Once halted by a misaligned target, later redirects are ignored until reset.
  assign redirect_eff = redirect && !halted;
  assign instr_valid  = (count != '0);
  assign push         = (state == S_WAIT) && imem_rvalid && !discard && !redirect_eff;
  assign pop          = instr_valid && instr_ready && !redirect_eff;
  assign count_nxt    = count + CW'(push) - CW'(pop);

  assign imem_req  = (state == S_REQ);
  assign imem_addr = fetch_pc;
  assign instr_out = instr_valid ? data_mem[rd_ptr] : NOP;
  assign instr_pc  = instr_valid ? pc_mem[rd_ptr]   : 32'h0000_0000;

  always_comb begin
    state_nxt    = state;
    discard_nxt  = discard;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_IDLE: if (!halted && (count < DEPTH_C)) state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_nxt    = S_WAIT;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_nxt = 1'b0;
          state_nxt   = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A request still in flight when redirected must drain before the new fetch starts.
    if (misalign_hit) begin
      state_nxt   = S_IDLE;
      discard_nxt = 1'b0;
    end else if (redirect_eff) begin
      fetch_pc_nxt = redir_pc;
      if (((state == S_WAIT) && !imem_rvalid) || ((state == S_REQ) && imem_gnt)) begin
        state_nxt   = S_WAIT;
        discard_nxt = 1'b1;
      end else begin
        state_nxt   = S_REQ;
        discard_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
      if (redirect_eff) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage carries no reset; validity is governed entirely by count.
  always_ff @(posedge clk) begin
    if ((state == S_REQ) && imem_gnt) req_addr <= fetch_pc;
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_addr;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer with a latency-configurable memory responder.
module tb_instruction_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat = 1;
  logic [31:0] exp_pc;

  instruction_fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: grants every request, answers lat cycles after the grant.
  logic        pend = 1'b0, gprev = 1'b0;
  logic [31:0] paddr = 32'h0, gaddr = 32'h0;
  int          wc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      pend = 1'b0; gprev = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (gprev) begin pend = 1'b1; paddr = gaddr; wc = lat - 1; end
      if (pend) begin
        if (wc == 0) begin imem_rvalid = 1'b1; imem_rdata = word_of(paddr); pend = 1'b0; end
        else wc--;
      end
      imem_gnt = imem_req;
      gprev    = imem_gnt;
      gaddr    = imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_next(input string tag);
    int k = 0;
    while (!instr_valid && k < 60) begin step(); k++; end
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, exp_pc);
    chk({tag, "_data"}, instr_out, word_of(exp_pc));
    exp_pc = exp_pc + 32'd4;
    step();
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 60) begin step(); k++; end
    chk("wait_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    step();
    redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_out"}, instr_out, 32'h0000_0013);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_mis"}, {31'd0, fetch_misaligned}, 32'd0);
  endtask

  initial begin
    // Reset state and zero-wait startup latency.
    step(); step();
    check_reset_outputs("rst");
    reset = 1'b1;
    step();
    chk("p1_req", {31'd0, imem_req}, 32'd1);
    chk("p1_addr", imem_addr, 32'h0);
    step();
    chk("p2_req", {31'd0, imem_req}, 32'd0);
    chk("p2_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("p3_valid", {31'd0, instr_valid}, 32'd1);
    chk("p3_pc", instr_pc, 32'h0);
    chk("p3_data", instr_out, word_of(32'h0));
    chk("p3_addr", imem_addr, 32'h4);
    exp_pc = 32'h4;
    step();
    for (int i = 0; i < 3; i++) check_next("seq");

    // Stall: buffer fills to DEPTH and fetching stops.
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_pc", instr_pc, exp_pc);
    step(); step();
    chk("stall_pc2", instr_pc, exp_pc);
    chk("stall_data2", instr_out, word_of(exp_pc));
    chk("stall_req2", {31'd0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'd0, instr_valid}, 32'd1);
      chk("drain_pc", instr_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      step();
    end
    check_next("post_drain");

    // Redirect while waiting on a slow memory: stale response dropped.
    lat = 3;
    wait_req();
    step();
    chk("wait_state_req", {31'd0, imem_req}, 32'd0);
    do_redirect(32'h0000_0100);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd0);
    exp_pc = 32'h0000_0100;
    check_next("redir_wait");
    check_next("redir_wait");

    // Redirect coinciding with a grant.
    lat = 1;
    wait_req();
    do_redirect(32'h0000_0200);
    exp_pc = 32'h0000_0200;
    check_next("redir_gnt");
    check_next("redir_gnt");

    // Fetch address wrap.
    do_redirect(32'hFFFF_FFFC);
    exp_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) check_next("wrap");

    // Reset pulse while a slow request is outstanding.
    lat = 3;
    wait_req();
    step();
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    lat = 1;
    step(); step();
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    exp_pc = 32'h0;
    check_next("restart");
    check_next("restart");

    // Misaligned redirect target.
`ifdef FETCH_MISALIGN_CHECK_EN
    do_redirect(32'h0000_0102);
    chk("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    do_redirect(32'h0000_0300);
    for (int i = 0; i < 3; i++) step();
    chk("mis_sticky", {31'd0, fetch_misaligned}, 32'd1);
    chk("mis_req2", {31'd0, imem_req}, 32'd0);
    chk("mis_valid2", {31'd0, instr_valid}, 32'd0);
`else
    do_redirect(32'h0000_0102);
    chk("mis_flag", {31'd0, fetch_misaligned}, 32'd0);
    exp_pc = 32'h0000_0100;
    check_next("mis_forced");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
